// File: rtl/ex_mem_latch.sv
// rtl/ex_mem_latch.sv - EX/MEM pipeline register with data-memory handshake
// Captures execute results, owns the dmem request until dhit, and holds a sticky halt.
module ex_mem_latch #(
  parameter int WORD_W = 32,
  parameter int RSEL_W = 5,
  parameter int CNT_W  = 8
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              exW,
  input  logic              exFLUSH,
  input  logic              excuDRE,
  input  logic              excuDWE,
  input  logic              excuHALT,
  input  logic              exMemToReg,
  input  logic              exWEN,
  input  logic              exJALflag,
  input  logic [WORD_W-1:0] exaluout,
  input  logic [WORD_W-1:0] exrdat2,
  input  logic [WORD_W-1:0] exnpc,
  input  logic [RSEL_W-1:0] exwsel,
  input  logic              dhit,
  input  logic [WORD_W-1:0] dmemload,
  output logic              dmemREN,
  output logic              dmemWEN,
  output logic [WORD_W-1:0] dmemaddr,
  output logic [WORD_W-1:0] dmemstore,
  output logic              memMemToReg,
  output logic              memWEN,
  output logic              memJALflag,
  output logic [WORD_W-1:0] memaluout,
  output logic [WORD_W-1:0] memnpc,
  output logic [WORD_W-1:0] memdload,
  output logic [RSEL_W-1:0] memwsel,
  output logic              memstall,
  output logic              memhalt,
  output logic [CNT_W-1:0]  memstallcnt
);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] ACCESS = 2'd1;
  localparam logic [1:0] DONE   = 2'd2;

  logic [1:0]        state_q, state_d;
  logic              dre_q, dre_d, dwe_q, dwe_d, haltc_q, haltc_d;
  logic              m2r_q, m2r_d, wen_q, wen_d, jal_q, jal_d;
  logic [WORD_W-1:0] alu_q, alu_d, rdat2_q, rdat2_d, npc_q, npc_d, dload_q, dload_d;
  logic [RSEL_W-1:0] wsel_q, wsel_d;
  logic              halt_q, halt_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              in_access;
  logic              take_mem;

  assign in_access = (state_q == ACCESS);
  assign memstall  = in_access & ~dhit;
  assign take_mem  = ~exFLUSH & (excuDRE | excuDWE);

  always_comb begin
    state_d = state_q;
    dre_d   = dre_q;
    dwe_d   = dwe_q;
    haltc_d = haltc_q;
    m2r_d   = m2r_q;
    wen_d   = wen_q;
    jal_d   = jal_q;
    alu_d   = alu_q;
    rdat2_d = rdat2_q;
    npc_d   = npc_q;
    wsel_d  = wsel_q;
    dload_d = dload_q;

    if (halt_q) begin
      // Frozen after a retired HALT; only reset releases the stage.
    end else if (in_access) begin
      if (dhit) begin
        state_d = DONE;
        if (dre_q & ~dwe_q) dload_d = dmemload;
      end
    end else if (exW) begin
      state_d = take_mem ? ACCESS : IDLE;
      dload_d = '0;
      if (exFLUSH) begin
        dre_d   = 1'b0;
        dwe_d   = 1'b0;
        haltc_d = 1'b0;
        m2r_d   = 1'b0;
        wen_d   = 1'b0;
        jal_d   = 1'b0;
        alu_d   = '0;
        rdat2_d = '0;
        npc_d   = '0;
        wsel_d  = '0;
      end else begin
        dre_d   = excuDRE;
        dwe_d   = excuDWE;
        haltc_d = excuHALT;
        m2r_d   = exMemToReg;
        wen_d   = exWEN;
        jal_d   = exJALflag;
        alu_d   = exaluout;
        rdat2_d = exrdat2;
        npc_d   = exnpc;
        wsel_d  = exwsel;
      end
    end

    // A HALT paired with a memory op waits for the access to finish.
    halt_d = halt_q | (haltc_q & ~in_access);
    cnt_d  = (memstall && (cnt_q != {CNT_W{1'b1}})) ? cnt_q + 1'b1 : cnt_q;
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= IDLE;
      dre_q   <= 1'b0;
      dwe_q   <= 1'b0;
      haltc_q <= 1'b0;
      m2r_q   <= 1'b0;
      wen_q   <= 1'b0;
      jal_q   <= 1'b0;
      alu_q   <= '0;
      rdat2_q <= '0;
      npc_q   <= '0;
      wsel_q  <= '0;
      dload_q <= '0;
      halt_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      dre_q   <= dre_d;
      dwe_q   <= dwe_d;
      haltc_q <= haltc_d;
      m2r_q   <= m2r_d;
      wen_q   <= wen_d;
      jal_q   <= jal_d;
      alu_q   <= alu_d;
      rdat2_q <= rdat2_d;
      npc_q   <= npc_d;
      wsel_q  <= wsel_d;
      dload_q <= dload_d;
      halt_q  <= halt_d;
      cnt_q   <= cnt_d;
    end
  end

  assign dmemREN     = in_access & dre_q & ~dwe_q;
  assign dmemWEN     = in_access & dwe_q;
  assign dmemaddr    = alu_q;
  assign dmemstore   = rdat2_q;
  assign memMemToReg = m2r_q;
  assign memWEN      = wen_q;
  assign memJALflag  = jal_q;
  assign memaluout   = alu_q;
  assign memnpc      = npc_q;
  assign memdload    = dload_q;
  assign memwsel     = wsel_q;
  assign memhalt     = halt_q;
  assign memstallcnt = cnt_q;

endmodule

// File: tb/tb_ex_mem_latch.sv
// tb/tb_ex_mem_latch.sv - directed bench for ex_mem_latch
module tb_ex_mem_latch;
  logic        CLK = 1'b0;
  logic        RST, exW, exFLUSH, excuDRE, excuDWE, excuHALT, exMemToReg, exWEN, exJALflag;
  logic [31:0] exaluout, exrdat2, exnpc, dmemload;
  logic [4:0]  exwsel;
  logic        dhit;
  logic        dmemREN, dmemWEN, memMemToReg, memWEN, memJALflag, memstall, memhalt;
  logic [31:0] dmemaddr, dmemstore, memaluout, memnpc, memdload;
  logic [4:0]  memwsel;
  logic [7:0]  memstallcnt;

  int nvec = 0;
  int nerr = 0;

  always #5 CLK = ~CLK;

  ex_mem_latch dut (
    .CLK(CLK), .RST(RST), .exW(exW), .exFLUSH(exFLUSH),
    .excuDRE(excuDRE), .excuDWE(excuDWE), .excuHALT(excuHALT),
    .exMemToReg(exMemToReg), .exWEN(exWEN), .exJALflag(exJALflag),
    .exaluout(exaluout), .exrdat2(exrdat2), .exnpc(exnpc), .exwsel(exwsel),
    .dhit(dhit), .dmemload(dmemload),
    .dmemREN(dmemREN), .dmemWEN(dmemWEN), .dmemaddr(dmemaddr), .dmemstore(dmemstore),
    .memMemToReg(memMemToReg), .memWEN(memWEN), .memJALflag(memJALflag),
    .memaluout(memaluout), .memnpc(memnpc), .memdload(memdload), .memwsel(memwsel),
    .memstall(memstall), .memhalt(memhalt), .memstallcnt(memstallcnt)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic clear_ex();
    exW = 0; exFLUSH = 0; excuDRE = 0; excuDWE = 0; excuHALT = 0;
    exMemToReg = 0; exWEN = 0; exJALflag = 0;
    exaluout = 0; exrdat2 = 0; exnpc = 0; exwsel = 0;
  endtask

  initial begin
    RST = 1; dhit = 0; dmemload = 32'h0;
    exW = 1; exFLUSH = 0; excuDRE = 1; excuDWE = 0; excuHALT = 1;
    exMemToReg = 1; exWEN = 1; exJALflag = 1;
    exaluout = $urandom; exrdat2 = $urandom; exnpc = $urandom; exwsel = 5'($urandom);
    tick();
    tick();
    check("rst_ren", dmemREN, 0);
    check("rst_wen_mem", dmemWEN, 0);
    check("rst_aluout", memaluout, 0);
    check("rst_npc", memnpc, 0);
    check("rst_store", dmemstore, 0);
    check("rst_wsel", memwsel, 0);
    check("rst_ctl", {memMemToReg, memWEN, memJALflag}, 0);
    check("rst_stall", memstall, 0);
    check("rst_halt", memhalt, 0);
    check("rst_cnt", memstallcnt, 0);

    // ALU op, no memory
    RST = 0; clear_ex();
    exW = 1; exaluout = 32'h1234; exwsel = 5; exWEN = 1; exnpc = 32'h404; exJALflag = 1;
    tick();
    check("alu_aluout", memaluout, 32'h1234);
    check("alu_wsel", memwsel, 5);
    check("alu_wen", memWEN, 1);
    check("alu_npc", memnpc, 32'h404);
    check("alu_jal", memJALflag, 1);
    check("alu_stall", memstall, 0);
    check("alu_ren", dmemREN, 0);

    // Load with a 3-cycle wait; exW held high with new data to prove it is ignored
    clear_ex();
    exW = 1; excuDRE = 1; exaluout = 32'h80; exMemToReg = 1; exWEN = 1; exwsel = 3;
    tick();
    exaluout = 32'h999; exwsel = 9; excuDRE = 0;
    check("ld1_ren", dmemREN, 1);
    check("ld1_addr", dmemaddr, 32'h80);
    check("ld1_stall", memstall, 1);
    tick();
    check("ld2_ren", dmemREN, 1);
    check("ld2_addr", dmemaddr, 32'h80);
    check("ld2_stall", memstall, 1);
    tick();
    dhit = 1; dmemload = 32'hDEADBEEF; #1;
    check("ld3_ren", dmemREN, 1);
    check("ld3_addr", dmemaddr, 32'h80);
    check("ld3_stall", memstall, 0);
    tick();
    dhit = 0; dmemload = 32'h0;
    check("ld_dload", memdload, 32'hDEADBEEF);
    check("ld_cnt", memstallcnt, 2);
    check("ld_ren_done", dmemREN, 0);
    check("ld_hold_alu", memaluout, 32'h80);
    check("ld_hold_wsel", memwsel, 3);

    // Store with immediate hit (the DONE state accepts this load)
    clear_ex();
    exW = 1; excuDWE = 1; exrdat2 = 32'hCAFE; exaluout = 32'h40;
    tick();
    exW = 0; dhit = 1; #1;
    check("st_wen", dmemWEN, 1);
    check("st_ren", dmemREN, 0);
    check("st_store", dmemstore, 32'hCAFE);
    check("st_addr", dmemaddr, 32'h40);
    check("st_stall", memstall, 0);
    check("st_dload_clr", memdload, 0);
    tick();
    dhit = 0;
    check("st_wen_done", dmemWEN, 0);
    check("st_cnt", memstallcnt, 2);
    tick();
    check("st_done_hold", dmemWEN, 0);
    check("st_done_store", dmemstore, 32'hCAFE);

    // Flush bubble
    clear_ex();
    exW = 1; exFLUSH = 1; excuDWE = 1; exWEN = 1; exaluout = 32'h55;
    tick();
    check("fl_wen_mem", dmemWEN, 0);
    check("fl_wen", memWEN, 0);
    check("fl_alu", memaluout, 0);
    check("fl_stall", memstall, 0);

    // Flush without exW does nothing
    clear_ex();
    exW = 1; exWEN = 1; exwsel = 7;
    tick();
    exW = 0; exFLUSH = 1;
    tick();
    check("fl_noexw_wen", memWEN, 1);
    check("fl_noexw_wsel", memwsel, 7);

    // Halt: latched at load, sticky at the following edge, then frozen
    clear_ex();
    exW = 1; excuHALT = 1; exaluout = 32'h77;
    tick();
    exW = 0; excuHALT = 0;
    check("ht_not_yet", memhalt, 0);
    tick();
    check("ht_set", memhalt, 1);
    exW = 1; exaluout = 32'h1111; exWEN = 1;
    tick();
    tick();
    check("ht_frozen_alu", memaluout, 32'h77);
    check("ht_frozen_wen", memWEN, 0);
    check("ht_sticky", memhalt, 1);

    RST = 1; clear_ex();
    tick();
    RST = 0;
    check("ht_rst", memhalt, 0);
    check("ht_rst_cnt", memstallcnt, 0);

    // Halt paired with a load waits for dhit
    exW = 1; excuDRE = 1; excuHALT = 1; exaluout = 32'h60;
    tick();
    exW = 0;
    tick();
    check("htm_wait", memhalt, 0);
    dhit = 1; #1;
    tick();
    dhit = 0;
    check("htm_pending", memhalt, 0);
    tick();
    check("htm_set", memhalt, 1);

    RST = 1; clear_ex();
    tick();
    RST = 0;

    // Saturating counter: 300 stall cycles
    exW = 1; excuDRE = 1; exaluout = 32'h20;
    tick();
    exW = 0;
    for (int i = 0; i < 300; i++) tick();
    check("sat_cnt", memstallcnt, 8'hFF);
    check("sat_ren", dmemREN, 1);

    // Reset mid-access abandons the request
    RST = 1;
    tick();
    check("rma_ren", dmemREN, 0);
    check("rma_stall", memstall, 0);
    check("rma_cnt", memstallcnt, 0);
    RST = 0;
    tick();
    check("rma_idle", dmemREN, 0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
